bram_sdp: RTL and testbench

Parametrised simple-dual-port block RAM with per-byte write mask: one write port, one read port. It is the successor to the fixed 512x32 byte-masked RAM and is used as the backing store behind TileLink slave buffers and scratchpads. Additions over that RAM:
- read enable with a valid strobe
- selectable read-during-write behaviour
- optional output pipeline register
- hardware clear sequencer that zeroes the array after reset or on request

---
 rtl/bram_pkg.sv | 17 +
 rtl/bram_sdp_array.sv | 37 +++
 rtl/bram_sdp.sv | 159 +++++++++++++++
 tb/tb_bram_sdp.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/bram_pkg.sv
// Shared constants and types for the simple-dual-port block RAM.
// Read-during-write selectors, clear FSM states and byte-lane helper.
package bram_pkg;

  localparam int RDW_OLD = 0;
  localparam int RDW_NEW = 1;

  typedef enum logic {
    CLR_IDLE,
    CLR_SWEEP
  } clr_state_t;

  function automatic int bytes_of(input int w);
    return w / 8;
  endfunction

endpackage

// File: rtl/bram_sdp_array.sv
// Bare byte-masked storage with a registered read port.
// No reset and no bypass so synthesis can map it onto block RAM.
module bram_sdp_array
  import bram_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 512,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        rd_en,
  input  logic [ADDR_W-1:0]           rd_addr,
  output logic [DATA_W-1:0]           rd_data,
  input  logic                        we,
  input  logic [ADDR_W-1:0]           wr_addr,
  input  logic [DATA_W-1:0]           wr_data,
  input  logic [bytes_of(DATA_W)-1:0] wr_bm
);

  localparam int NB = bytes_of(DATA_W);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
    if (we) begin
      for (int b = 0; b < NB; b++) begin
        if (wr_bm[b]) begin
          mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/bram_sdp.sv
// Simple-dual-port RAM: clear sequencer, write-port mux,
// read-during-write merge, optional output stage, valid pipeline.
module bram_sdp
  import bram_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int DEPTH          = 512,
  parameter int ADDR_W         = $clog2(DEPTH),
  parameter int OUT_REG        = 0,
  parameter int RDW_MODE       = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  rd_en_i,
  input  logic [ADDR_W-1:0]     rd_addr_i,
  output logic [DATA_W-1:0]     rd_data_o,
  output logic                  rd_valid_o,
  input  logic                  wr_en_i,
  input  logic [ADDR_W-1:0]     wr_addr_i,
  input  logic [DATA_W-1:0]     wr_data_i,
  input  logic [DATA_W/8-1:0]   wr_bm_i,
  input  logic                  clear_i,
  output logic                  busy_o
);

  localparam int NB = bytes_of(DATA_W);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(DEPTH);

  clr_state_t        state;
  logic [ADDR_W-1:0] cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= (CLEAR_ON_RESET != 0) ? CLR_SWEEP : CLR_IDLE;
      cnt   <= '0;
    end else begin
      unique case (state)
        CLR_IDLE: begin
          if (clear_i) begin
            state <= CLR_SWEEP;
            cnt   <= '0;
          end
        end
        CLR_SWEEP: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= CLR_IDLE;
          end
        end
        default: state <= CLR_IDLE;
      endcase
    end
  end

  assign busy_o = (state == CLR_SWEEP);

  logic wr_ok, rd_acc, rd_in;

  assign wr_ok  = wr_en_i & ~busy_o & ({1'b0, wr_addr_i} < LIMIT);
  assign rd_acc = rd_en_i & ~busy_o;
  assign rd_in  = {1'b0, rd_addr_i} < LIMIT;

  logic              a_we;
  logic [ADDR_W-1:0] a_waddr;
  logic [DATA_W-1:0] a_wdata;
  logic [NB-1:0]     a_bm;
  logic [DATA_W-1:0] a_q;

  assign a_we    = busy_o | wr_ok;
  assign a_waddr = busy_o ? cnt : wr_addr_i;
  assign a_wdata = busy_o ? '0 : wr_data_i;
  assign a_bm    = busy_o ? '1 : wr_bm_i;

  bram_sdp_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk     (clk_i),
    .rd_en   (rd_acc & rd_in),
    .rd_addr (rd_addr_i),
    .rd_data (a_q),
    .we      (a_we),
    .wr_addr (a_waddr),
    .wr_data (a_wdata),
    .wr_bm   (a_bm)
  );

  // s1_zero also covers the post-reset state, before any read lands
  logic s1_valid, s1_zero;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid <= 1'b0;
      s1_zero  <= 1'b1;
    end else begin
      s1_valid <= rd_acc;
      if (rd_acc) begin
        s1_zero <= ~rd_in;
      end
    end
  end

  logic [DATA_W-1:0] s1_word, s1_data;

  if (RDW_MODE == RDW_NEW) begin : g_bypass
    logic              s1_hit;
    logic [DATA_W-1:0] s1_wdata;
    logic [NB-1:0]     s1_bm;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        s1_hit <= 1'b0;
      end else if (rd_acc) begin
        s1_hit <= wr_ok & (wr_addr_i == rd_addr_i);
      end
    end

    always_ff @(posedge clk_i) begin
      if (rd_acc) begin
        s1_wdata <= wr_data_i;
        s1_bm    <= wr_bm_i;
      end
    end

    always_comb begin
      s1_word = a_q;
      for (int b = 0; b < NB; b++) begin
        if (s1_hit && s1_bm[b]) begin
          s1_word[8*b +: 8] = s1_wdata[8*b +: 8];
        end
      end
    end
  end else begin : g_old
    assign s1_word = a_q;
  end

  assign s1_data = s1_zero ? '0 : s1_word;

  if (OUT_REG != 0) begin : g_oreg
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        rd_valid_o <= 1'b0;
        rd_data_o  <= '0;
      end else begin
        rd_valid_o <= s1_valid;
        if (s1_valid) begin
          rd_data_o <= s1_data;
        end
      end
    end
  end else begin : g_direct
    assign rd_valid_o = s1_valid;
    assign rd_data_o  = s1_data;
  end

endmodule

// File: tb/tb_bram_sdp.sv
// Scoreboard bench driving three bram_sdp variants in lockstep.
// d0: 8x32 old-data, d1: 8x32 OUT_REG new-data, d2: 6x32 new-data.
module tb_bram_sdp;

  localparam int N = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd_en, wr_en, clear;
  logic [2:0]  rd_addr, wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_bm;

  logic [31:0] rdata [N];
  logic        rvalid [N];
  logic        busy [N];

  always #5 clk = ~clk;

  bram_sdp #(.DATA_W(32), .DEPTH(8), .OUT_REG(0),
             .RDW_MODE(0), .CLEAR_ON_RESET(1)) d0 (
    .clk_i(clk), .rst_i(rst), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
    .rd_data_o(rdata[0]), .rd_valid_o(rvalid[0]), .wr_en_i(wr_en),
    .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_bm_i(wr_bm),
    .clear_i(clear), .busy_o(busy[0]));

  bram_sdp #(.DATA_W(32), .DEPTH(8), .OUT_REG(1),
             .RDW_MODE(1), .CLEAR_ON_RESET(1)) d1 (
    .clk_i(clk), .rst_i(rst), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
    .rd_data_o(rdata[1]), .rd_valid_o(rvalid[1]), .wr_en_i(wr_en),
    .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_bm_i(wr_bm),
    .clear_i(clear), .busy_o(busy[1]));

  bram_sdp #(.DATA_W(32), .DEPTH(6), .OUT_REG(0),
             .RDW_MODE(1), .CLEAR_ON_RESET(1)) d2 (
    .clk_i(clk), .rst_i(rst), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
    .rd_data_o(rdata[2]), .rd_valid_o(rvalid[2]), .wr_en_i(wr_en),
    .wr_addr_i(wr_addr), .wr_data_i(wr_data), .wr_bm_i(wr_bm),
    .clear_i(clear), .busy_o(busy[2]));

  typedef struct {
    logic [31:0] d;
    int          due;
  } exp_t;

  exp_t sb [N][$];
  int   lat [N] = '{1, 2, 1};
  int   sweep [N] = '{8, 8, 6};
  int   busy_cnt [N];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    rd_en = 0; rd_addr = '0; wr_en = 0; wr_addr = '0;
    wr_data = '0; wr_bm = '0; clear = 0;
  endtask

  task automatic op(input bit rd, input logic [2:0] ra,
                    input bit wr, input logic [2:0] wa,
                    input logic [31:0] wd, input logic [3:0] bm,
                    input bit clr, input bit expv,
                    input logic [31:0] e0, input logic [31:0] e1,
                    input logic [31:0] e2);
    exp_t x;
    logic [31:0] e [N];
    e[0] = e0; e[1] = e1; e[2] = e2;
    rd_en = rd; rd_addr = ra; wr_en = wr; wr_addr = wa;
    wr_data = wd; wr_bm = bm; clear = clr;
    if (rd && expv) begin
      for (int i = 0; i < N; i++) begin
        x.d = e[i];
        x.due = cyc + lat[i];
        sb[i].push_back(x);
      end
    end
    @(posedge clk); #1;
    idle();
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] e0,
                    input logic [31:0] e1, input logic [31:0] e2);
    op(1, a, 0, 0, 0, 0, 0, 1, e0, e1, e2);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d,
                    input logic [3:0] bm);
    op(0, 0, 1, a, d, bm, 0, 0, 0, 0, 0);
  endtask

  task automatic wait_idle(input string name);
    bit done = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(posedge clk); #1;
      done = !(busy[0] | busy[1] | busy[2]);
    end
    chk({name, " idle"}, 32'(done), 32'd1);
    for (int i = 0; i < N; i++)
      chk($sformatf("%s busy cycles d%0d", name, i),
          busy_cnt[i], sweep[i]);
  endtask

  task automatic drain(input string name);
    repeat (4) @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      chk($sformatf("%s pending d%0d", name, i), sb[i].size(), 0);
  endtask

  initial begin
    idle();
    fork
      forever begin
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
          busy_cnt[i] += int'(busy[i]);
          if (!rst && rvalid[i]) begin
            if (sb[i].size() == 0) begin
              n_chk++;
              n_fail++;
              $display("FAIL unexpected valid d%0d: got %h expected none",
                       i, rdata[i]);
            end else begin
              exp_t x;
              x = sb[i].pop_front();
              chk($sformatf("rd_data d%0d", i), rdata[i], x.d);
              chk($sformatf("rd_latency d%0d", i), cyc, x.due);
            end
          end
        end
      end
    join_none

    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("reset rd_data d%0d", i), rdata[i], 32'h0);
      chk($sformatf("reset rd_valid d%0d", i), 32'(rvalid[i]), 32'h0);
      chk($sformatf("reset busy d%0d", i), 32'(busy[i]), 32'h1);
    end
    @(posedge clk); #1;
    rst = 0;
    foreach (busy_cnt[i]) busy_cnt[i] = 0;
    wait_idle("power-up sweep");

    // preload, then a reset pulse must wipe everything again
    for (int a = 0; a < 8; a++) wr(3'(a), 32'hA5A50000 | a, 4'hF);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    foreach (busy_cnt[i]) busy_cnt[i] = 0;
    wait_idle("reset sweep");
    for (int a = 0; a < 8; a++) rd(3'(a), 0, 0, 0);
    drain("reset sweep");

    wr(3, 32'hAABBCCDD, 4'b1111);
    wr(3, 32'h11223344, 4'b0101);
    rd(3, 32'hAA22CC44, 32'hAA22CC44, 32'hAA22CC44);
    drain("byte mask");
    for (int i = 0; i < N; i++) begin
      chk($sformatf("hold rd_data d%0d", i), rdata[i], 32'hAA22CC44);
      chk($sformatf("hold rd_valid d%0d", i), 32'(rvalid[i]), 32'h0);
    end

    op(1, 5, 1, 5, 32'hFFFFFFFF, 4'b0011, 0, 1,
       32'h00000000, 32'h0000FFFF, 32'h0000FFFF);
    rd(5, 32'h0000FFFF, 32'h0000FFFF, 32'h0000FFFF);
    drain("rdw");

    rd(0, 0, 0, 0);
    rd(1, 0, 0, 0);
    rd(2, 0, 0, 0);
    @(posedge clk); #1;
    rd(3, 32'hAA22CC44, 32'hAA22CC44, 32'hAA22CC44);
    drain("pipeline");

    foreach (busy_cnt[i]) busy_cnt[i] = 0;
    op(0, 0, 1, 2, 32'h12345678, 4'hF, 1, 0, 0, 0, 0);
    for (int k = 0; k < 6; k++)
      op(1, 2, 1, 2, 32'h12345678, 4'hF, k == 2, 0, 0, 0, 0);
    wait_idle("clear");
    rd(2, 0, 0, 0);
    rd(3, 0, 0, 0);
    drain("clear");

    wr(4, 32'h5555AAAA, 4'hF);
    rd(4, 32'h5555AAAA, 32'h5555AAAA, 32'h5555AAAA);
    wr(7, 32'hDEADBEEF, 4'hF);
    rd(7, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0);
    for (int a = 0; a < 6; a++) begin
      if (a == 4) rd(3'(a), 32'h5555AAAA, 32'h5555AAAA, 32'h5555AAAA);
      else rd(3'(a), 0, 0, 0);
    end
    drain("out of range");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
